// File: rtl/dft_ctrl_mc_if.sv
// Host-side op/commit handshake bundle for the multi-chain DFT scan/dump controller.
`timescale 1ns/1ps
interface dft_ctrl_mc_if #(
  parameter int NCHAINS = 4,
  parameter int LEN_W   = 32
);
  logic               val_op;
  logic               op_ack;
  logic [NCHAINS-1:0] chain_mask;
  logic [LEN_W-1:0]   chain_len;
  logic               op_commit;
  logic               commit_ack;
  logic               busy;

  modport master (
    output val_op, chain_mask, chain_len, commit_ack,
    input  op_ack, op_commit, busy
  );

  modport slave (
    input  val_op, chain_mask, chain_len, commit_ack,
    output op_ack, op_commit, busy
  );
endinterface

// File: rtl/dft_ctrl_mc.sv
// Multi-chain DFT scan/dump controller: scans each masked chain into the word buffer, then dumps it.
// Optional abort support is enabled with the DFT_CTRL_MC_ABORT_EN macro.
`timescale 1ns/1ps
module dft_ctrl_mc #(
  parameter int NCHAINS = 4,
  parameter int WORD_W  = 32,
  parameter int LEN_W   = 32,
  parameter int CH_W    = (NCHAINS > 1) ? $clog2(NCHAINS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  dft_ctrl_mc_if.slave       host,
`ifdef DFT_CTRL_MC_ABORT_EN
  input  logic               abort,
  output logic               op_aborted,
`endif
  output logic               dft_out_strobe,
  output logic [CH_W-1:0]    dft_out_chain,
  output logic [NCHAINS-1:0] sc_sen,
  output logic [NCHAINS-1:0] sc_ce,
  output logic [CH_W-1:0]    chain_sel,
  output logic               buf_op,
  output logic               buf_sin_sel,
  output logic               buf_val_op,
  output logic               buf_reset,
  input  logic               buf_op_ack,
  input  logic               buf_op_commit,
  input  logic               buf_scaning
);
  localparam int WSH   = $clog2(WORD_W);
  localparam int PTR_W = CH_W + 1;

  typedef enum logic [3:0] {
    IDLE, SEL, SCAN_RST, SCAN_PREP, SCAN, DUMP_RST, DUMP_PREP, DUMP, FINISH
  } state_t;

  state_t             state_reg;
  logic [NCHAINS-1:0] mask_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   bit_cnt_reg;
  logic [LEN_W:0]     word_cnt_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [CH_W-1:0]    cur_reg;
  logic               strobe_reg;
  logic [CH_W-1:0]    strobe_chain_reg;

  logic [LEN_W:0]     nwords;
  logic               found;
  logic [CH_W-1:0]    found_idx;
  logic               bits_left;
  logic               shift_en;
  logic               sen_active;
  logic               words_done;
  logic               kill;

`ifdef DFT_CTRL_MC_ABORT_EN
  logic aborted_reg;
  assign kill       = abort & (state_reg != IDLE) & (state_reg != FINISH);
  assign op_aborted = aborted_reg & (state_reg == FINISH);
`else
  assign kill = 1'b0;
`endif

  // Extra bit keeps the round-up from wrapping when len is near its maximum.
  assign nwords     = ({1'b0, len_reg} + (LEN_W+1)'(WORD_W - 1)) >> WSH;
  assign words_done = (word_cnt_reg == nwords);
  assign bits_left  = (bit_cnt_reg < len_reg);
  assign shift_en   = (state_reg == SCAN) & bits_left & buf_scaning & ~kill;
  assign sen_active = (state_reg inside {SCAN_RST, SCAN_PREP, SCAN, DUMP_RST, DUMP_PREP, DUMP}) & ~kill;

  // Lowest set mask bit at or above ptr; descending loop leaves the lowest hit.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NCHAINS - 1; i >= 0; i--) begin
      if (mask_reg[i] && (PTR_W'(i) >= ptr_reg)) begin
        found     = 1'b1;
        found_idx = CH_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NCHAINS; gi++) begin : g_chain
    assign sc_sen[gi] = sen_active & (cur_reg == CH_W'(gi));
    assign sc_ce[gi]  = shift_en & (cur_reg == CH_W'(gi));
  end

  assign host.op_ack    = (state_reg == IDLE) & host.val_op;
  assign host.busy      = (state_reg != IDLE);
  assign host.op_commit = (state_reg == FINISH);

  assign buf_op      = ~(state_reg inside {SCAN_RST, SCAN_PREP, SCAN});
  assign buf_reset   = (state_reg inside {IDLE, SCAN_RST, DUMP_RST});
  assign buf_val_op  = ((state_reg == SCAN_PREP) | (state_reg == DUMP_PREP)) & ~words_done & ~kill;
  assign buf_sin_sel = (state_reg == SCAN) & bits_left & ~kill;
  assign chain_sel   = cur_reg;

  assign dft_out_strobe = strobe_reg;
  assign dft_out_chain  = strobe_chain_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      mask_reg         <= '0;
      len_reg          <= '0;
      bit_cnt_reg      <= '0;
      word_cnt_reg     <= '0;
      ptr_reg          <= '0;
      cur_reg          <= '0;
      strobe_reg       <= 1'b0;
      strobe_chain_reg <= '0;
`ifdef DFT_CTRL_MC_ABORT_EN
      aborted_reg      <= 1'b0;
`endif
    end else begin
      strobe_reg <= 1'b0;
`ifdef DFT_CTRL_MC_ABORT_EN
      if (kill) begin
        state_reg   <= FINISH;
        aborted_reg <= 1'b1;
      end else
`endif
      begin
        case (state_reg)
          IDLE: begin
            if (host.val_op) begin
              mask_reg  <= host.chain_mask;
              len_reg   <= host.chain_len;
              ptr_reg   <= '0;
              state_reg <= SEL;
`ifdef DFT_CTRL_MC_ABORT_EN
              aborted_reg <= 1'b0;
`endif
            end
          end
          SEL: begin
            if (!found || (len_reg == '0)) begin
              state_reg <= FINISH;
            end else begin
              cur_reg   <= found_idx;
              state_reg <= SCAN_RST;
            end
          end
          SCAN_RST: begin
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            state_reg    <= SCAN_PREP;
          end
          SCAN_PREP: begin
            if (words_done) begin
              state_reg <= DUMP_RST;
            end else if (buf_op_ack) begin
              state_reg <= SCAN;
            end
          end
          SCAN: begin
            if (shift_en) begin
              bit_cnt_reg <= bit_cnt_reg + LEN_W'(1);
            end
            if (buf_op_commit) begin
              word_cnt_reg <= word_cnt_reg + (LEN_W+1)'(1);
              state_reg    <= SCAN_PREP;
            end
          end
          DUMP_RST: begin
            word_cnt_reg <= '0;
            state_reg    <= DUMP_PREP;
          end
          DUMP_PREP: begin
            if (words_done) begin
              ptr_reg   <= PTR_W'(cur_reg) + PTR_W'(1);
              state_reg <= SEL;
            end else if (buf_op_ack) begin
              state_reg <= DUMP;
            end
          end
          DUMP: begin
            if (buf_op_commit) begin
              word_cnt_reg     <= word_cnt_reg + (LEN_W+1)'(1);
              strobe_reg       <= 1'b1;
              strobe_chain_reg <= cur_reg;
              state_reg        <= DUMP_PREP;
            end
          end
          FINISH: begin
            if (host.commit_ack) begin
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dft_ctrl_mc.sv
// Self-checking bench for dft_ctrl_mc: randomized buffer responder, counting monitor, arithmetic reference model.
`timescale 1ns/1ps
module tb_dft_ctrl_mc;
  localparam int NCHAINS = 4;
  localparam int WORD_W  = 32;
  localparam int LEN_W   = 32;
  localparam int CH_W    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dft_ctrl_mc_if #(.NCHAINS(NCHAINS), .LEN_W(LEN_W)) host ();

  logic               dft_out_strobe;
  logic [CH_W-1:0]    dft_out_chain;
  logic [NCHAINS-1:0] sc_sen, sc_ce;
  logic [CH_W-1:0]    chain_sel;
  logic               buf_op, buf_sin_sel, buf_val_op, buf_reset;
  logic               buf_op_ack, buf_op_commit, buf_scaning;
`ifdef DFT_CTRL_MC_ABORT_EN
  logic abort, op_aborted;
`endif

  dft_ctrl_mc #(.NCHAINS(NCHAINS), .WORD_W(WORD_W), .LEN_W(LEN_W), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .host(host),
`ifdef DFT_CTRL_MC_ABORT_EN
    .abort(abort), .op_aborted(op_aborted),
`endif
    .dft_out_strobe(dft_out_strobe), .dft_out_chain(dft_out_chain),
    .sc_sen(sc_sen), .sc_ce(sc_ce), .chain_sel(chain_sel),
    .buf_op(buf_op), .buf_sin_sel(buf_sin_sel), .buf_val_op(buf_val_op), .buf_reset(buf_reset),
    .buf_op_ack(buf_op_ack), .buf_op_commit(buf_op_commit), .buf_scaning(buf_scaning)
  );

  int checks = 0;
  int failures = 0;

  // buffer responder state
  int phase = 0, remain = 0, hold_cnt = 0, held_seen = 0, wr_words = 0, rd_words = 0;
  bit cur_write = 1'b0;
  bit rsp_flush = 1'b0;

  // monitor state
  int ce_cnt[NCHAINS];
  int pad_cnt = 0, sen_viol = 0;
  int strobes[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Buffer model: ack (after optional hold), WORD_W shift cycles with random gaps, then one commit cycle.
  initial begin
    buf_op_ack = 1'b0; buf_op_commit = 1'b0; buf_scaning = 1'b0;
    forever begin
      @(negedge clk);
      buf_op_ack = 1'b0; buf_op_commit = 1'b0; buf_scaning = 1'b0;
      if (reset || rsp_flush) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (buf_val_op) begin
               if (hold_cnt > 0) begin
                 hold_cnt--; held_seen++;
               end else begin
                 buf_op_ack = 1'b1;
                 cur_write = !buf_op;
                 if (cur_write) wr_words++; else rd_words++;
                 remain = WORD_W;
                 phase = 1;
               end
             end
          1: begin
               if ($urandom_range(0, 3) != 0) begin
                 buf_scaning = 1'b1;
                 remain--;
               end
               if (remain == 0) phase = 2;
             end
          default: begin
               buf_op_commit = 1'b1;
               phase = 0;
             end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < NCHAINS; i++) if (sc_ce[i]) ce_cnt[i]++;
      if (buf_scaning && !buf_op && !buf_sin_sel) pad_cnt++;
      if (dft_out_strobe) strobes.push_back(int'(dft_out_chain));
      if (!$onehot0(sc_sen)) sen_viol++;
      if ((sc_ce & ~sc_sen) != '0) sen_viol++;
    end
  end

  task automatic clear_counts(input int hold);
    for (int i = 0; i < NCHAINS; i++) ce_cnt[i] = 0;
    pad_cnt = 0; sen_viol = 0; strobes.delete();
    wr_words = 0; rd_words = 0; held_seen = 0; hold_cnt = hold;
  endtask

  task automatic start_op(input logic [3:0] mask, input int len, input string tag);
    @(negedge clk); #1;
    host.val_op = 1'b1; host.chain_mask = mask; host.chain_len = len;
    #1;
    check({tag, ":op_ack"}, host.op_ack, 1);
    @(negedge clk); #1;
    host.val_op = 1'b0; host.chain_mask = 4'($urandom); host.chain_len = $urandom;
    #1;
    check({tag, ":busy"}, host.busy, 1);
  endtask

  task automatic run_op(input logic [3:0] mask, input int len, input int hold, input string tag);
    int n;
    int nw;
    int exp_words;
    int exp_pad;
    int exp_str[$];
    clear_counts(hold);
    start_op(mask, len, tag);
    n = 1;
    while (!host.op_commit && n < 20000) begin
      @(negedge clk); #2;
      n++;
    end
    check({tag, ":commit_reached"}, host.op_commit, 1);
    if (mask == 4'b0000 || len == 0) check({tag, ":finish_latency"}, n, 2);
    @(negedge clk); #1;
    check({tag, ":commit_held"}, host.op_commit, 1);
    host.commit_ack = 1'b1;
    @(negedge clk); #1;
    host.commit_ack = 1'b0;
    check({tag, ":idle_after_ack"}, {host.busy, host.op_commit}, 0);

    nw = (len + WORD_W - 1) / WORD_W;
    exp_words = 0; exp_pad = 0;
    for (int c = 0; c < NCHAINS; c++) begin
      check($sformatf("%s:ce_cnt%0d", tag, c), ce_cnt[c], mask[c] ? len : 0);
      if (mask[c]) begin
        for (int w = 0; w < nw; w++) exp_str.push_back(c);
        exp_words += nw;
        exp_pad += nw * WORD_W - len;
      end
    end
    check({tag, ":strobe_count"}, strobes.size(), exp_str.size());
    for (int i = 0; i < exp_str.size(); i++)
      if (i < strobes.size()) check($sformatf("%s:strobe%0d_chain", tag, i), strobes[i], exp_str[i]);
    check({tag, ":write_words"}, wr_words, exp_words);
    check({tag, ":read_words"}, rd_words, exp_words);
    check({tag, ":pad_bits"}, pad_cnt, exp_pad);
    check({tag, ":sen_onehot"}, sen_viol, 0);
    check({tag, ":ack_hold"}, held_seen, (exp_words > 0) ? hold : 0);
  endtask

  task automatic wait_bit10(input string tag);
    int n;
    n = 0;
    while (ce_cnt[0] < 10 && n < 2000) begin
      @(negedge clk); #2;
      n++;
    end
    check({tag, ":reached_bit10"}, ce_cnt[0], 10);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b1;
    host.val_op = 1'b0; host.chain_mask = '0; host.chain_len = '0; host.commit_ack = 1'b0;
`ifdef DFT_CTRL_MC_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #2;
    check("rst:busy_ack_commit", {host.busy, host.op_ack, host.op_commit}, 0);
    check("rst:sen_ce", {sc_sen, sc_ce}, 0);
    check("rst:bufop_bufreset", {buf_op, buf_reset}, 2'b11);
    check("rst:valop_sinsel_chsel", {buf_val_op, buf_sin_sel, chain_sel}, 0);
    check("rst:strobe_chain", {dft_out_strobe, dft_out_chain}, 0);
    @(negedge clk); #1;
    reset = 1'b0;

    run_op(4'b0001, 32, 0, "m1_l32");
    run_op(4'b0001, 33, 0, "m1_l33");
    run_op(4'b0000, 40, 0, "m0");
    run_op(4'b1111, 0, 0, "l0");
    run_op(4'b0100, 20, 5, "ack_hold5");
    run_op(4'b1010, 64, 0, "m1010_l64");

    // reset in the middle of the scan of chain 0
    clear_counts(0);
    start_op(4'b0001, 32, "rst_mid");
    wait_bit10("rst_mid");
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid:busy_commit", {host.busy, host.op_commit}, 0);
    check("rst_mid:sen_ce", {sc_sen, sc_ce}, 0);
    check("rst_mid:bufop_bufreset", {buf_op, buf_reset}, 2'b11);
    check("rst_mid:valop_sinsel_chsel", {buf_val_op, buf_sin_sel, chain_sel}, 0);
    check("rst_mid:strobe_chain", {dft_out_strobe, dft_out_chain}, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    check("rst_mid:no_strobes", strobes.size(), 0);
    run_op(4'b0001, 32, 0, "post_reset");

`ifdef DFT_CTRL_MC_ABORT_EN
    clear_counts(0);
    start_op(4'b0001, 32, "abort");
    wait_bit10("abort");
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort:commit_aborted", {host.op_commit, op_aborted}, 2'b11);
    check("abort:sen_ce", {sc_sen, sc_ce}, 0);
    @(negedge clk); #1;
    abort = 1'b0; rsp_flush = 1'b1;
    check("abort:aborted_held", op_aborted, 1);
    host.commit_ack = 1'b1;
    @(negedge clk); #1;
    host.commit_ack = 1'b0; rsp_flush = 1'b0;
    check("abort:idle", {host.busy, op_aborted}, 0);
    check("abort:no_strobes", strobes.size(), 0);
    run_op(4'b0011, 40, 0, "post_abort");
`endif

    for (int k = 0; k < 8; k++)
      run_op(4'($urandom_range(0, 15)), $urandom_range(0, 80), $urandom_range(0, 3), $sformatf("rand%0d", k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dft_ctrl_mc.md
# dft_ctrl_mc

Multi-chain DFT scan/dump controller. It serially scans each scan chain selected in a per-operation mask into the word buffer, then dumps that chain's buffered words to the DFT output port before moving to the next chain. It sits between the host op/commit handshake and the scan chains plus the shared word buffer. It generalises the single-chain controller in chain count, word width and counter width.

## Interface
- NCHAINS, 4, number of scan chains (1..16)
- WORD_W, 32, buffer word width in bits; must be a power of two
- LEN_W, 32, width of chain length and bit counter
- CH_W, $clog2(NCHAINS) (minimum 1), chain index width
- clk  in  1  sole clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- val_op  in  1  operation request
- op_ack  out  1  request accepted; = (state==IDLE) & val_op
- chain_mask  in  NCHAINS  chains to process; latched on accept
- chain_len  in  LEN_W  bits per chain, same for every chain; latched on accept
- op_commit  out  1  high while in FINISH
- commit_ack  in  1  host releases FINISH
- busy  out  1  state != IDLE
- dft_out_strobe  out  1  registered; one-cycle pulse per dumped word
- dft_out_chain  out  CH_W  registered chain index accompanying dft_out_strobe
- sc_sen  out  NCHAINS  scan enable, one-hot on the current chain from SCAN_RST through DUMP
- sc_ce  out  NCHAINS  scan clock enable, one-hot on the current chain
- chain_sel  out  CH_W  buffer serial-input mux select (current chain)
- buf_op  out  1  0 = write (scan), 1 = read (dump)
- buf_sin_sel  out  1  1 = chain data, 0 = zero padding
- buf_val_op, buf_reset  out  1  buffer word request and buffer clear
- buf_op_ack, buf_op_commit, buf_scaning  in  1  buffer request accept, word done, shifting active

## Operation
- States: IDLE, SEL, SCAN_RST, SCAN_PREP, SCAN, DUMP_RST, DUMP_PREP, DUMP, FINISH.
- IDLE: buf_reset=1, buf_op=1. On val_op: latch mask and length, clear ptr, go to SEL.
- SEL: Find the lowest set mask bit at index >= ptr.
  - If none is found, or the latched length is 0, go to FINISH.
  - Otherwise load cur=index and go to SCAN_RST.
- SCAN_RST: Assert buf_reset. Clear bit_cnt and word_cnt. Go to SCAN_PREP.
- SCAN_PREP: Set buf_op=0.
  - If word_cnt==nwords, go to DUMP_RST.
  - Otherwise hold buf_val_op=1 until buf_op_ack, then go to SCAN.
- SCAN: While bit_cnt < len, sc_ce[cur] = buf_scaning, buf_sin_sel=1, and bit_cnt increments on each sc_ce cycle.
  - Once bit_cnt == len: sc_ce=0, buf_sin_sel=0 (zero padding).
  - On buf_op_commit: word_cnt+1, go to SCAN_PREP.
- DUMP_RST: Assert buf_reset with buf_op=1. Clear word_cnt. Go to DUMP_PREP.
- DUMP_PREP: Set buf_op=1.
  - If word_cnt==nwords, set ptr=cur+1 and go to SEL.
  - Otherwise hold buf_val_op=1 until buf_op_ack, then go to DUMP.
- DUMP: On buf_op_commit, word_cnt+1, register strobe with chain=cur, go to DUMP_PREP.
- FINISH: Hold op_commit=1 until commit_ack, then go to IDLE.
- nwords = (len + WORD_W - 1) >> log2(WORD_W), computed at LEN_W+1 bits so len near max does not overflow.
- ptr == NCHAINS (after the last chain): SEL finds none and goes to FINISH.
- Mask bits above NCHAINS-1 do not exist. Mask or length changes after accept are ignored.

## Timing
- Reset values:
  - state IDLE, busy 0, op_ack 0 (if val_op=0), op_commit 0.
  - sc_sen, sc_ce, buf_val_op, buf_sin_sel 0; chain_sel 0.
  - buf_op 1, buf_reset 1.
  - dft_out_strobe 0, dft_out_chain 0.
- Reset asserted mid-operation: IDLE on the next edge, with no further strobes.
- buf_val_op stays high until the buffer samples it with buf_op_ack; the move to SCAN/DUMP happens on that edge.
- Chain scan cost: exactly len sc_ce cycles, summed over words.
- dft_out_strobe rises 1 cycle after the buf_op_commit edge in DUMP.
- Mask 0: val_op accepted, FINISH 2 cycles after op_ack.
- Between chains there is 1 SEL cycle.

## Configuration
- DFT_CTRL_MC_ABORT_EN defined:
  - Adds input abort and output op_aborted.
  - abort in any state other than IDLE/FINISH forces FINISH on the next edge. op_aborted=1 throughout that FINISH.
  - All sc_sen/sc_ce drop immediately.
  - An in-flight word produces no strobe.
- Undefined: neither port exists, and every operation runs to completion.

## Test plan
- NCHAINS=4, WORD_W=32, mask=4'b0001, len=32: sc_ce[0] high for exactly 32 cycles, 1 write word, 1 read word, 1 strobe with chain 0, then op_commit until commit_ack.
- mask=4'b0001, len=33: 33 sc_ce cycles, 2 write and 2 read words, 2 strobes, 31 padding bits with buf_sin_sel=0.
- mask=4'b1010, len=64: chain 1 is fully scanned and dumped before chain 3 starts; strobes carry chains 1,1,3,3; sc_sen is never on two chains at once.
- mask=0, or len=0: op_ack, then FINISH 2 cycles later, zero strobes, zero sc_ce.
- buf_op_ack withheld for 5 cycles in SCAN_PREP: buf_val_op held 5+ cycles, no sc_ce, and no progress until ack.
- Reset asserted in SCAN at bit 10 of 32: next cycle all outputs at reset values. A new op with len=32 then runs cleanly for 32 sc_ce cycles. With the macro, abort at the same point gives FINISH next edge with op_aborted=1 and 0 strobes.
